// File: rtl/multi_bank_output_serializer_pkg.sv
// Shared constants and FSM encoding for the multi-bank output serializer.
// Holds no logic: only the default geometry and the state type.
package multi_bank_output_serializer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_NUM_BANKS  = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_SHIFT = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/multi_bank_output_serializer_piso.sv
// Parallel-load shift register feeding the serial output; load wins over shift.
// bit_o always shows the next bit to send, so it is valid the cycle after a load.
module piso_shift_reg #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bit_o
);

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[DATA_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = MSB_FIRST ? sr_q[DATA_WIDTH-1] : sr_q[0];

endmodule

// File: rtl/multi_bank_output_serializer.sv
// Streams word_count words from one SRAM bank out one bit per cycle while debug_en is held.
// First bit 4 edges after debug_en is first sampled; no backpressure, dropping debug_en aborts.
module multi_bank_output_serializer
  import multi_bank_output_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         debug_en,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_select,
  input  logic [ADDR_WIDTH:0]          word_count,
  output logic                         rd_en,
  output logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         serial_out,
  output logic                         serial_out_valid,
  output logic                         done
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int LW = ADDR_WIDTH + 1;

  logic                  en_q1;
  logic                  en_q2;
  state_t                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [LW-1:0]         left_q,   left_d;
  logic [BW-1:0]         bank_q,   bank_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic                  pf_q,     pf_d;
  logic                  done_q,   done_d;
  logic                  rd_en_c;
  logic                  load_c;
  logic                  shift_c;
  logic                  sr_bit;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    pf_d    = pf_q;
    done_d  = 1'b0;
    rd_en_c = 1'b0;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q2) begin
          bank_d = bank_select;
          left_d = word_count;
          addr_d = '0;
          if (word_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH, ST_LOAD, ST_SHIFT: begin
        if (!en_q2) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          cnt_d   = '0;
          pf_d    = 1'b0;
        end else if (state_q == ST_FETCH) begin
          rd_en_c = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          left_d  = left_q - LW'(1);
          state_d = ST_LOAD;
        end else if (state_q == ST_LOAD) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d = '0;
          if (pf_q) begin
            load_c = 1'b1;
            pf_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          shift_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          // Fetch two bits early so the word lands exactly as the last bit leaves.
          if (cnt_q == CW'(DATA_WIDTH - 2) && left_q != '0) begin
            rd_en_c = 1'b1;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            left_d  = left_q - LW'(1);
            pf_d    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!en_q2) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q1   <= 1'b0;
      en_q2   <= 1'b0;
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      bank_q  <= '0;
      cnt_q   <= '0;
      pf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q1   <= debug_en;
      en_q2   <= en_q1;
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      pf_q    <= pf_d;
      done_q  <= done_d;
    end
  end

  piso_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .shift_i (shift_c),
    .data_i  (rd_data),
    .bit_o   (sr_bit)
  );

  // Gating with en_q2 drops valid on the edge that sees the request go away.
  assign serial_out_valid = (state_q == ST_SHIFT) && en_q2;
  assign serial_out       = serial_out_valid & sr_bit;
  assign rd_en            = rd_en_c;
  assign rd_bank          = bank_q;
  assign rd_addr          = addr_q;
  assign done             = done_q;

endmodule

// File: tb/tb_multi_bank_output_serializer.sv
// Directed bench: LSB/MSB serializer instances share stimulus; a 4-bit-wide instance covers the full-bank wrap.
module tb_multi_bank_output_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        debug_en = 1'b0;
  logic [1:0]  bank_select = '0;
  logic [12:0] word_count = '0;
  logic [15:0] rd_data = '0;
  logic [3:0]  rd_data_w = '0;

  logic        rd_en, rd_en_m, rd_en_w;
  logic [1:0]  rd_bank, rd_bank_m, rd_bank_w;
  logic [11:0] rd_addr, rd_addr_m, rd_addr_w;
  logic        serial_out, serial_out_m, serial_out_w;
  logic        valid, valid_m, valid_w;
  logic        done, done_m, done_w;

  bit mode_idx = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int n_valid, n_runs, n_rden, n_done, done_cyc, first_valid, first_rden;
  int addr_err, bank_err, word_err, word_err_m, zero_err;
  int w_rden, w_addr_err, w_valid, w_done;
  logic [11:0] w_addr_at_done;
  logic [15:0] seq_l, seq_m;
  bit timed_out;

  always #5 clk = ~clk;

  multi_bank_output_serializer #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .NUM_BANKS(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .bank_select(bank_select), .word_count(word_count),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .serial_out(serial_out), .serial_out_valid(valid), .done(done));

  multi_bank_output_serializer #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .NUM_BANKS(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .debug_en(debug_en), .bank_select(bank_select), .word_count(word_count),
    .rd_en(rd_en_m), .rd_bank(rd_bank_m), .rd_addr(rd_addr_m), .rd_data(rd_data),
    .serial_out(serial_out_m), .serial_out_valid(valid_m), .done(done_m));

  multi_bank_output_serializer #(.DATA_WIDTH(4), .ADDR_WIDTH(12), .NUM_BANKS(4), .MSB_FIRST(1'b0)) dut_w (
    .clk(clk), .rst(rst), .debug_en(debug_en), .bank_select(bank_select), .word_count(word_count),
    .rd_en(rd_en_w), .rd_bank(rd_bank_w), .rd_addr(rd_addr_w), .rd_data(rd_data_w),
    .serial_out(serial_out_w), .serial_out_valid(valid_w), .done(done_w));

  // SRAM models: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mode_idx ? 16'(rd_addr) : 16'h15c6;
    if (rd_en_w) rd_data_w <= rd_addr_w[3:0];
  end

  task automatic run_stream(input logic [1:0] bank, input logic [12:0] wc, input int max_cyc, input bit use_w);
    int cyc, stop_at, bitpos, widx, exp_addr, w_exp;
    logic [15:0] cur, cur_m, exp_word;
    bit prev_v;
    n_valid = 0; n_runs = 0; n_rden = 0; n_done = 0; done_cyc = 0; first_valid = 0; first_rden = 0;
    addr_err = 0; bank_err = 0; word_err = 0; word_err_m = 0; zero_err = 0;
    w_rden = 0; w_addr_err = 0; w_valid = 0; w_done = 0; w_addr_at_done = 12'hfff;
    seq_l = 'x; seq_m = 'x;
    cur = '0; cur_m = '0; bitpos = 0; widx = 0; exp_addr = 0; w_exp = 0; prev_v = 1'b0;
    @(negedge clk);
    bank_select = bank; word_count = wc; debug_en = 1'b1;
    cyc = 0; stop_at = max_cyc;
    while (cyc < stop_at) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        bank_select = ~bank;
        word_count  = 13'd1;
      end
      if (rd_en) begin
        if (n_rden == 0) first_rden = cyc;
        n_rden++;
        if (rd_addr !== 12'(exp_addr)) addr_err++;
        if (rd_bank !== bank) bank_err++;
        exp_addr++;
      end
      if (valid) begin
        if (first_valid == 0) first_valid = cyc;
        if (!prev_v) n_runs++;
        if (n_valid < 16) begin
          seq_l[n_valid] = serial_out;
          seq_m[n_valid] = serial_out_m;
        end
        n_valid++;
        cur[bitpos] = serial_out;
        cur_m[15 - bitpos] = serial_out_m;
        bitpos++;
        if (bitpos == 16) begin
          exp_word = mode_idx ? 16'(widx) : 16'h15c6;
          if (cur !== exp_word) word_err++;
          if (cur_m !== exp_word) word_err_m++;
          widx++;
          bitpos = 0;
        end
      end else if (serial_out !== 1'b0 || serial_out_m !== 1'b0) begin
        zero_err++;
      end
      prev_v = valid;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (!use_w && stop_at > cyc + 3) stop_at = cyc + 3;
      end
      if (rd_en_w) begin
        w_rden++;
        if (rd_addr_w !== 12'(w_exp)) w_addr_err++;
        w_exp++;
      end
      if (valid_w) w_valid++;
      if (done_w) begin
        w_done++;
        w_addr_at_done = rd_addr_w;
        if (use_w && stop_at > cyc + 3) stop_at = cyc + 3;
      end
    end
    timed_out = use_w ? (w_done == 0) : (n_done == 0);
    debug_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; debug_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en, rd_bank, rd_addr, serial_out, valid, done} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {rd_en, rd_bank, rd_addr, serial_out, valid, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_single;
    mode_idx = 1'b0;
    run_stream(2'd1, 13'd1, 200, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL lsb_timeout: got no done, required done"); end
    n_checks++; if (first_rden !== 3) begin n_fail++; $display("FAIL lsb_first_rden: got %0d required 3", first_rden); end
    n_checks++; if (first_valid !== 5) begin n_fail++; $display("FAIL lsb_first_valid: got %0d required 5", first_valid); end
    n_checks++; if (seq_l !== 16'h15c6) begin n_fail++; $display("FAIL lsb_bits: got %h required 15c6", seq_l); end
    n_checks++; if (n_valid !== 16 || n_runs !== 1) begin n_fail++; $display("FAIL lsb_valid: got %0d/%0d required 16/1", n_valid, n_runs); end
    n_checks++; if (n_done !== 1 || done_cyc !== 21) begin n_fail++; $display("FAIL lsb_done: got %0d@%0d required 1@21", n_done, done_cyc); end
    n_checks++; if (n_rden !== 1 || addr_err !== 0 || bank_err !== 0) begin n_fail++; $display("FAIL lsb_read: got %0d/%0d/%0d required 1/0/0", n_rden, addr_err, bank_err); end
    n_checks++; if (zero_err !== 0) begin n_fail++; $display("FAIL lsb_idle_zero: got %0d required 0", zero_err); end
  endtask

  task automatic test_msb_single;
    mode_idx = 1'b0;
    run_stream(2'd0, 13'd1, 200, 1'b0);
    n_checks++; if (seq_m !== 16'h63a8) begin n_fail++; $display("FAIL msb_bits: got %h required 63a8", seq_m); end
    n_checks++; if (word_err_m !== 0) begin n_fail++; $display("FAIL msb_word: got %0d required 0", word_err_m); end
  endtask

  task automatic test_bank2_stream;
    mode_idx = 1'b1;
    run_stream(2'd2, 13'd1275, 21000, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL b2_timeout: got no done, required done"); end
    n_checks++; if (n_valid !== 20400 || n_runs !== 1) begin n_fail++; $display("FAIL b2_valid: got %0d/%0d required 20400/1", n_valid, n_runs); end
    n_checks++; if (n_rden !== 1275 || addr_err !== 0) begin n_fail++; $display("FAIL b2_addr: got %0d/%0d required 1275/0", n_rden, addr_err); end
    n_checks++; if (bank_err !== 0) begin n_fail++; $display("FAIL b2_bank: got %0d required 0", bank_err); end
    n_checks++; if (word_err !== 0 || word_err_m !== 0) begin n_fail++; $display("FAIL b2_words: got %0d/%0d required 0/0", word_err, word_err_m); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL b2_done: got %0d required 1", n_done); end
  endtask

  task automatic test_full_bank_wrap;
    mode_idx = 1'b1;
    run_stream(2'd3, 13'd4096, 17000, 1'b1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL wrap_timeout: got no done, required done"); end
    n_checks++; if (w_rden !== 4096 || w_addr_err !== 0) begin n_fail++; $display("FAIL wrap_addr: got %0d/%0d required 4096/0", w_rden, w_addr_err); end
    n_checks++; if (w_addr_at_done !== 12'd0) begin n_fail++; $display("FAIL wrap_final_addr: got %0d required 0", w_addr_at_done); end
    n_checks++; if (w_valid !== 16384 || w_done !== 1) begin n_fail++; $display("FAIL wrap_valid: got %0d/%0d required 16384/1", w_valid, w_done); end
  endtask

  task automatic test_abort;
    int cyc, vcount, dn, rda;
    mode_idx = 1'b0;
    @(negedge clk);
    bank_select = 2'd1; word_count = 13'd4; debug_en = 1'b1;
    cyc = 0; vcount = 0;
    while (vcount < 37 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (valid) vcount++;
    end
    n_checks++; if (vcount !== 37) begin n_fail++; $display("FAIL abort_reach: got %0d required 37", vcount); end
    debug_en = 1'b0;
    dn = 0; rda = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
      if (rd_en) rda++;
    end
    n_checks++; if (valid !== 1'b0 || serial_out !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b/%b required 0/0", valid, serial_out); end
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
      if (rd_en) rda++;
    end
    n_checks++; if (dn !== 0 || rda !== 0) begin n_fail++; $display("FAIL abort_quiet: got done=%0d rd_en=%0d required 0/0", dn, rda); end
    run_stream(2'd3, 13'd1, 200, 1'b0);
    n_checks++; if (n_rden !== 1 || addr_err !== 0 || bank_err !== 0) begin n_fail++; $display("FAIL abort_restart: got %0d/%0d/%0d required 1/0/0", n_rden, addr_err, bank_err); end
    n_checks++; if (n_done !== 1 || seq_l !== 16'h15c6) begin n_fail++; $display("FAIL abort_restart_data: got %0d/%h required 1/15c6", n_done, seq_l); end
  endtask

  task automatic test_zero_words;
    mode_idx = 1'b0;
    run_stream(2'd2, 13'd0, 100, 1'b0);
    n_checks++; if (n_done !== 1 || done_cyc !== 3) begin n_fail++; $display("FAIL zero_done: got %0d@%0d required 1@3", n_done, done_cyc); end
    n_checks++; if (n_valid !== 0 || n_rden !== 0) begin n_fail++; $display("FAIL zero_activity: got %0d/%0d required 0/0", n_valid, n_rden); end
  endtask

  task automatic test_reset_midstream;
    int cyc, dn, vc;
    mode_idx = 1'b0;
    @(negedge clk);
    bank_select = 2'd2; word_count = 13'd10; debug_en = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (valid !== 1'b1 || rd_addr !== 12'd2 || rd_bank !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre: got v=%b addr=%0d bank=%0d required 1/2/2", valid, rd_addr, rd_bank); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rd_en, rd_bank, rd_addr, serial_out, valid, done} !== 18'd0 ||
        {rd_en_m, rd_bank_m, rd_addr_m, serial_out_m, valid_m, done_m} !== 18'd0 ||
        {rd_en_w, rd_bank_w, rd_addr_w, serial_out_w, valid_w, done_w} !== 18'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h required 0", {rd_en, rd_bank, rd_addr, serial_out, valid, done});
    end
    debug_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dn = 0; vc = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (done) dn++;
      if (valid) vc++;
    end
    n_checks++; if (dn !== 0 || vc !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got done=%0d valid=%0d required 0/0", dn, vc); end
  endtask

  initial begin
    test_reset();
    test_lsb_single();
    test_msb_single();
    test_zero_words();
    test_abort();
    test_reset_midstream();
    test_bank2_stream();
    test_full_bank_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_bank_output_serializer.md
MULTI_BANK_OUTPUT_SERIALIZER -- requirements
Module: multi_bank_output_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning SRAM word width and bits per serialized word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning SRAM read-address width.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning the number of selectable SRAM banks, with NUM_BANKS >= 2.
REQ-004 SHALL have parameter MSB_FIRST, default 0; 0 sends bit 0 first, 1 sends bit DATA_WIDTH-1 first.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port debug_en, input, 1 bit; a level request to stream; it is asynchronous to the stream and double-registered.
REQ-008 SHALL have port bank_select, input, clog2(NUM_BANKS) bits, selecting the source bank.
REQ-009 SHALL have port word_count, input, ADDR_WIDTH+1 bits, giving the number of words to stream (0 to 2^ADDR_WIDTH).
REQ-010 SHALL have port rd_en, output, 1 bit, an SRAM read strobe.
REQ-011 SHALL have port rd_bank, output, clog2(NUM_BANKS) bits, the bank being read.
REQ-012 SHALL have port rd_addr, output, ADDR_WIDTH bits, the word address.
REQ-013 SHALL have port rd_data, input, DATA_WIDTH bits, valid exactly one cycle after rd_en.
REQ-014 SHALL have port serial_out, output, 1 bit, the serialized data.
REQ-015 SHALL have port serial_out_valid, output, 1 bit, high for every cycle in which serial_out carries a payload bit.
REQ-016 SHALL have port done, output, 1 bit, a one-cycle pulse at stream end.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, LOAD, SHIFT, DONE.
REQ-018 SHALL treat the second debug_en register stage (en_q2) as the only control view of debug_en.
REQ-019 SHALL, in IDLE with en_q2 high, latch bank_select and word_count, set the address to 0, and enter FETCH; later changes on these inputs SHALL be ignored until the next start.
REQ-020 SHALL, in FETCH, assert rd_en for one cycle with rd_bank set to the latched bank and rd_addr set to the current address, then enter LOAD.
REQ-021 SHALL, in LOAD, capture rd_data into the shift register and enter SHIFT.
REQ-022 SHALL give the first valid bit on serial_out, with serial_out_valid high, in the 4th cycle after the edge that first samples debug_en high.
REQ-023 SHALL, in SHIFT, emit one bit per cycle in the order set by MSB_FIRST, for DATA_WIDTH cycles per word.
REQ-024 SHALL prefetch the next word by pulsing rd_en DATA_WIDTH-2 cycles into each word, so consecutive words stream with no gap; serial_out_valid SHALL stay high for exactly DATA_WIDTH*word_count consecutive cycles.
REQ-025 SHALL increment the address by 1 per fetched word, wrapping modulo 2^ADDR_WIDTH; word_count = 2^ADDR_WIDTH streams the whole bank once with no re-read.
REQ-026 SHALL, after the last bit, drop serial_out_valid, pulse done for one cycle, and enter DONE.
REQ-027 SHALL, with word_count = 0, skip FETCH: done SHALL pulse one cycle after the start, serial_out_valid SHALL never rise, and the FSM SHALL enter DONE.
REQ-028 SHALL, in DONE, hold the FSM until en_q2 is low, then clear the address to 0 and return to IDLE; no reset is needed between streams.
REQ-029 SHALL, when en_q2 goes low in FETCH, LOAD or SHIFT (abort), go to IDLE on that same edge with serial_out_valid low from that edge, no done pulse, no further rd_en, and the address cleared.
REQ-030 SHALL hold serial_out at 0 whenever serial_out_valid is low.

Reset
REQ-031 SHALL, with rst high at a rising edge, clear all of: FSM to IDLE, address, both debug_en stages, shift register and bit counter, and all outputs (rd_en, rd_bank, rd_addr, serial_out, serial_out_valid, done) to 0.
REQ-032 SHALL, when rst is asserted mid-stream, abort the stream immediately with no done pulse.
REQ-033 SHALL require debug_en to be re-sampled through both stages after rst deasserts before a new start.

Structure
REQ-034 SHALL place the FSM state typedef and the default DATA_WIDTH, ADDR_WIDTH and NUM_BANKS constants in the shared accelerator package.
REQ-035 SHALL implement the parallel-load shift register (parameters DATA_WIDTH and MSB_FIRST, with load and shift enables) as sub-module piso_shift_reg.

Verification
REQ-036 SHALL verify: word_count=1, rd_data=16'h15c6, MSB_FIRST=0 -> serial_out 0,1,1,0,0,0,1,1,1,0,1,0,1,0,0,0, with valid first high on the 4th cycle after debug_en is sampled, then done.
REQ-037 SHALL verify: same word with MSB_FIRST=1 -> serial_out 0,0,0,1,0,1,0,1,1,1,0,0,0,1,1,0.
REQ-038 SHALL verify: bank 2, word_count=1275, SRAM model word i = i -> 20400 contiguous valid cycles, rd_addr 0..1274 in order, every word recovered, one done pulse.
REQ-039 SHALL verify: word_count=4096 -> rd_addr runs 0..4095 once with no repeat, and the wrap leaves the address at 0.
REQ-040 SHALL verify: debug_en dropped after 37 valid bits -> valid low within 2 cycles, no done pulse, and the next stream starts at address 0 with bank_select re-latched.
REQ-041 SHALL verify: word_count=0 -> done pulse, zero valid cycles, zero rd_en; rst mid-stream -> all outputs 0 on the next edge.
